// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block.
//   state_t   : measurement FSM states
//   CNT_W_DEF : default width of the cycle counter and measurement outputs
package pwm_capture_pkg;

  localparam int unsigned CNT_W_DEF = 28;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Control and result bundle of the PWM capture block.
//   en, pwm_in           : driven by the user (master)
//   period_out, high_out : last measurement in cycles (0 on a stuck report)
//   meas_valid           : one-cycle pulse when the results update
//   stuck, level         : timeout report flag and line level at the timeout
interface pwm_capture_if import pwm_capture_pkg::*; #(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             en;
  logic             pwm_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             stuck;
  logic             level;

  modport master (
    output en, pwm_in,
    input  period_out, high_out, meas_valid, stuck, level
  );

  modport slave (
    input  en, pwm_in,
    output period_out, high_out, meas_valid, stuck, level
  );
endinterface

// File: rtl/pwm_capture_edge_sync.sv
// Two-flop synchroniser with edge detection for an asynchronous input.
//   int_osc : clock
//   rst     : asynchronous active-high reset
//   d_in    : asynchronous input
//   lvl     : synchronised level
//   rise    : one-cycle pulse on a synchronised 0->1 transition
//   fall    : one-cycle pulse on a synchronised 1->0 transition
module edge_sync (
  input  logic int_osc,
  input  logic rst,
  input  logic d_in,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic r_s1, r_s2, r_s3;

  always_ff @(posedge int_osc or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= d_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign lvl  = r_s2;
  assign rise = r_s2 & ~r_s3;
  assign fall = ~r_s2 & r_s3;
endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture. One report per complete period, or a
// single stuck report when no edge arrives for TIMEOUT cycles.
//   int_osc : clock
//   rst     : asynchronous active-high reset
//   bus     : control inputs and measurement results (slave side)
module pwm_capture import pwm_capture_pkg::*; #(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = 2**26
) (
  input  logic          int_osc,
  input  logic          rst,
  pwm_capture_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic w_lvl, w_rise, w_fall;

  edge_sync u_sync (
    .int_osc (int_osc),
    .rst     (rst),
    .d_in    (bus.pwm_in),
    .lvl     (w_lvl),
    .rise    (w_rise),
    .fall    (w_fall)
  );

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic [CNT_W-1:0] r_high_lat, w_high_lat_nx;
  logic [CNT_W-1:0] r_period, w_period_nx;
  logic [CNT_W-1:0] r_high, w_high_nx;
  logic             r_valid, w_valid_nx;
  logic             r_stuck, w_stuck_nx;
  logic             r_level, w_level_nx;
  logic             w_timeout;

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
  // An edge in the same cycle as the timeout count takes priority.
  assign w_timeout = (r_cnt == TO_CNT) && !w_rise && !w_fall;

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_high_lat_nx = r_high_lat;
    w_period_nx   = r_period;
    w_high_nx     = r_high;
    w_valid_nx    = 1'b0;
    w_stuck_nx    = r_stuck;
    w_level_nx    = r_level;

    if (!bus.en) begin
      w_state_nx = WAIT_RISE;
      w_cnt_nx   = '0;
    end else begin
      unique case (r_state)
        WAIT_RISE: begin
          if (w_rise) begin
            w_state_nx = MEAS_HIGH;
            w_cnt_nx   = CNT_ONE;
          end
        end
        MEAS_HIGH: begin
          w_cnt_nx = w_cnt_inc;
          if (w_fall) begin
            w_high_lat_nx = r_cnt;
            w_state_nx    = MEAS_LOW;
          end else if (w_timeout) begin
            w_period_nx = '0;
            w_high_nx   = '0;
            w_stuck_nx  = 1'b1;
            w_level_nx  = w_lvl;
            w_valid_nx  = 1'b1;
            w_state_nx  = WAIT_RISE;
            w_cnt_nx    = '0;
          end
        end
        MEAS_LOW: begin
          w_cnt_nx = w_cnt_inc;
          if (w_rise) begin
            w_period_nx = r_cnt;
            w_high_nx   = r_high_lat;
            w_stuck_nx  = 1'b0;
            w_level_nx  = 1'b0;
            w_valid_nx  = 1'b1;
            w_state_nx  = MEAS_HIGH;
            w_cnt_nx    = CNT_ONE;
          end else if (w_timeout) begin
            w_period_nx = '0;
            w_high_nx   = '0;
            w_stuck_nx  = 1'b1;
            w_level_nx  = w_lvl;
            w_valid_nx  = 1'b1;
            w_state_nx  = WAIT_RISE;
            w_cnt_nx    = '0;
          end
        end
        default: begin
          w_state_nx = WAIT_RISE;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge int_osc or posedge rst) begin
    if (rst) begin
      r_state    <= WAIT_RISE;
      r_cnt      <= '0;
      r_high_lat <= '0;
      r_period   <= '0;
      r_high     <= '0;
      r_valid    <= 1'b0;
      r_stuck    <= 1'b0;
      r_level    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_high_lat <= w_high_lat_nx;
      r_period   <= w_period_nx;
      r_high     <= w_high_nx;
      r_valid    <= w_valid_nx;
      r_stuck    <= w_stuck_nx;
      r_level    <= w_level_nx;
    end
  end

  assign bus.period_out = r_period;
  assign bus.high_out   = r_high;
  assign bus.meas_valid = r_valid;
  assign bus.stuck      = r_stuck;
  assign bus.level      = r_level;
endmodule
